// File: rtl/sort4_pkg.sv
// Shared types and the compare-exchange schedule for the sequential 4-element sorter.
package sort4_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef logic [2:0] step_t;
  typedef logic [1:0] idx_t;

  localparam int    N_STEPS   = 5;
  localparam step_t LAST_STEP = step_t'(N_STEPS - 1);

  // Five-comparator network for four keys: (0,1) (2,3) (1,3) (0,2) (1,2).
  function automatic idx_t pair_a(input step_t step);
    case (step)
      3'd0:    pair_a = 2'd0;
      3'd1:    pair_a = 2'd2;
      3'd2:    pair_a = 2'd1;
      3'd3:    pair_a = 2'd0;
      3'd4:    pair_a = 2'd1;
      default: pair_a = 2'd0;
    endcase
  endfunction

  function automatic idx_t pair_b(input step_t step);
    case (step)
      3'd0:    pair_b = 2'd1;
      3'd1:    pair_b = 2'd3;
      3'd2:    pair_b = 2'd3;
      3'd3:    pair_b = 2'd2;
      3'd4:    pair_b = 2'd2;
      default: pair_b = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/sort4_cmp_swap.sv
// Combinational compare-exchange: lo goes to the lower-indexed slot, hi to the higher.
// Define SORT4_DESC_EN to exchange when a<b (descending order) instead of a>b.
module sort4_cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

`ifdef SORT4_DESC_EN
  assign swapped = (a < b);
`else
  assign swapped = (a > b);
`endif

  assign lo = swapped ? b : a;
  assign hi = swapped ? a : b;

endmodule

// File: rtl/sort4_seq_ctrl.sv
// Sequential 4-element sorter: one shared compare-exchange unit walks a 5-step network.
// Optional SORT4_DESC_EN (in sort4_cmp_swap) flips the order; timing is unchanged.
module sort4_seq_ctrl
  import sort4_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out_data,
  output logic [2:0]     out_swaps,
  output logic [7:0]     sort_cnt
);

  state_t         state_q, state_d;
  step_t          step_q, step_d;
  logic [W-1:0]   elem_q [4];
  logic [W-1:0]   elem_d [4];
  logic [2:0]     swaps_q, swaps_d;
  logic [7:0]     cnt_q, cnt_d;

  logic           in_fire, out_fire;
  idx_t           idx_a, idx_b;
  logic [W-1:0]   cmp_a, cmp_b, cmp_lo, cmp_hi;
  logic           cmp_swapped;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign idx_a = pair_a(step_q);
  assign idx_b = pair_b(step_q);
  assign cmp_a = elem_q[idx_a];
  assign cmp_b = elem_q[idx_b];

  sort4_cmp_swap #(.W(W)) u_cmp_swap (
    .a       (cmp_a),
    .b       (cmp_b),
    .lo      (cmp_lo),
    .hi      (cmp_hi),
    .swapped (cmp_swapped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_fire) state_d = S_CMP;
      S_CMP:   if (step_q == LAST_STEP) state_d = S_DONE;
      S_DONE:  if (out_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath next-state: load in IDLE, one exchange per CMP cycle, count in DONE.
  always_comb begin
    step_d  = step_q;
    swaps_d = swaps_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 4; i++) begin
      elem_d[i] = elem_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          for (int i = 0; i < 4; i++) begin
            elem_d[i] = in_data[(4-i)*W-1 -: W];
          end
          swaps_d = 3'd0;
          step_d  = '0;
        end
      end
      S_CMP: begin
        elem_d[idx_a] = cmp_lo;
        elem_d[idx_b] = cmp_hi;
        if (cmp_swapped) swaps_d = swaps_q + 3'd1;
        step_d = (step_q == LAST_STEP) ? step_t'(0) : step_q + step_t'(1);
      end
      S_DONE: begin
        if (out_fire) cnt_d = cnt_q + 8'd1;
      end
      default: begin
        step_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q  <= '0;
      swaps_q <= 3'd0;
      cnt_q   <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        elem_q[i] <= '0;
      end
    end else begin
      step_q  <= step_d;
      swaps_q <= swaps_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) begin
        elem_q[i] <= elem_d[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_out
      assign out_data[gi*W +: W] = elem_q[gi];
    end
  endgenerate

  assign out_swaps = swaps_q;
  assign sort_cnt  = cnt_q;

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Directed bench for sort4_seq_ctrl (W=4, ascending build).
module tb_sort4_seq_ctrl;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [4*W-1:0] out_data;
  logic [2:0]     out_swaps;
  logic [7:0]     sort_cnt;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  sort4_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_swaps (out_swaps),
    .sort_cnt  (sort_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain bubble sort, smallest element ends up in [3:0].
  function automatic logic [15:0] ref_sort(input logic [15:0] d);
    logic [3:0] e [4];
    logic [3:0] t;
    logic [15:0] r;
    for (int i = 0; i < 4; i++) e[i] = d[(4-i)*4-1 -: 4];
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 3 - p; j++)
        if (e[j] > e[j+1]) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = e[i];
    return r;
  endfunction

  // Sends one word, checks latency/result, then completes the output handshake.
  task automatic run_word(input logic [15:0] din, input logic [15:0] exp_data,
                          input logic [2:0] exp_sw, input bit chk_sw);
    int lat;
    @(negedge clk);
    check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = din;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("latency", lat, 32'd5);
    check_val("out_data", {16'd0, out_data}, {16'd0, exp_data});
    if (chk_sw) check_val("out_swaps", {29'd0, out_swaps}, {29'd0, exp_sw});
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 8'd1;
    check_val("sort_cnt", {24'd0, sort_cnt}, {24'd0, exp_cnt});
    check_val("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    $display("word in=0x%04h out=0x%04h swaps=%0d cnt=%0d", din, out_data, out_swaps, sort_cnt);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_sort_cnt", {24'd0, sort_cnt}, 32'd0);
    check_val("rst_out_swaps", {29'd0, out_swaps}, 32'd0);
    check_val("rst_out_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_word(16'h4321, 16'h4321, 3'd4, 1'b1);
    run_word(16'h1234, 16'h4321, 3'd0, 1'b1);
    run_word(16'h7777, 16'h7777, 3'd0, 1'b1);
    run_word(16'h0F00, 16'hF000, 3'd1, 1'b1);
    run_word(16'hFEDC, 16'hFEDC, 3'd4, 1'b1);

    // Back-pressure: hold DONE for 10 cycles while a second word is offered.
    begin
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h9A05; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_data = 16'h1111;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check_val("hold_latency", lat, 32'd5);
      for (int c = 0; c < 10; c++) begin
        check_val("hold_data", {16'd0, out_data}, 32'h0000A950);
        check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("hold_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
      end
      check_val("hold_swaps", {29'd0, out_swaps}, 32'd2);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 8'd1;
      check_val("hold_sort_cnt", {24'd0, sort_cnt}, {24'd0, exp_cnt});
      check_val("hold_back_idle", {31'd0, in_ready}, 32'd1);
      $display("word in=0x9a05 out=0x%04h swaps=%0d cnt=%0d (held)", out_data, out_swaps, sort_cnt);
    end

    // Abort a word with reset during step 2.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h4321;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check_val("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("abort_sort_cnt", {24'd0, sort_cnt}, 32'd0);
    exp_cnt = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    run_word(16'h4321, 16'h4321, 3'd4, 1'b1);

    // Restart count from zero so the wrap lands exactly after 256 words.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    for (int n = 0; n < 256; n++) begin
      logic [15:0] w;
      w = 16'($urandom);
      run_word(w, ref_sort(w), 3'd0, 1'b0);
    end
    check_val("wrap_sort_cnt", {24'd0, sort_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
